// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer.
// Contents: register selector enum, CTRL bit positions, byte-lane merge helper.
package mmio_timer_pkg;

    // Register selected by addr[3:2] inside the 16-byte window.
    typedef enum logic [1:0] {
        RegCtrl    = 2'd0,
        RegCount   = 2'd1,
        RegCompare = 2'd2,
        RegStatus  = 2'd3
    } reg_sel_e;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlAutoBit  = 1;
    localparam int unsigned CtrlIrqEnBit = 2;
    localparam int unsigned CtrlPrescLsb = 8;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Data-memory bus between the CPU (master) and a responder (slave).
// Signals: ce (access valid), we (write), addr (byte address), sel (byte enables),
//          data_i (write data, master->slave), data_o (read data, slave->master).
interface mmio_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce, we, addr, sel, data_i, input data_o);
    modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler for the timer: counts 0..i_limit while enabled and pulses o_tick for one
// cycle when the count equals i_limit, then restarts from 0.
// Ports: clk, rst (sync, active-high), i_en (run), i_clr (restart, suppresses tick),
//        i_limit (terminal count), o_tick (one-cycle pulse).
module mmio_timer_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_limit,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_pre;
    logic [PRESC_W-1:0] w_pre_d;

    always_comb begin
        o_tick  = i_en && !i_clr && (r_pre == i_limit);
        w_pre_d = r_pre + PRESC_W'(1);
        if (!i_en || i_clr || o_tick) w_pre_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_pre <= '0;
        else     r_pre <= w_pre_d;
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the CPU data-memory bus.
// Window of 16 bytes at BASE_ADDR: CTRL (0x0), COUNT (0x4), COMPARE (0x8), STATUS (0xC).
// Ports: clk, rst (sync, active-high), bus (slave side of mmio_timer_if; zero-wait
//        combinational reads, byte-lane writes on the next edge), irq_o (MATCH & IRQ_EN).
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned PRESC_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus,
    output logic         irq_o
);

    localparam logic [31:0] CtrlMask =
        32'h0000_0007 | (((32'd1 << PRESC_W) - 32'd1) << CtrlPrescLsb);

    logic [31:0] r_ctrl, r_count, r_compare;
    logic        r_match;

    logic [31:0] w_ctrl_d, w_count_d, w_compare_d, w_cnt_ticked;
    logic        w_match_d, w_match_set, w_match_clr;
    logic        w_hit, w_wr, w_tick, w_ctrl_wr;
    reg_sel_e    w_reg_sel;
    logic        w_unused;

    assign w_hit     = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr      = w_hit && bus.we;
    assign w_reg_sel = reg_sel_e'(bus.addr[3:2]);
    assign w_ctrl_wr = w_wr && (w_reg_sel == RegCtrl);
    assign w_unused  = ^bus.addr[1:0];

    mmio_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_ctrl[CtrlEnBit]),
        .i_clr   (w_ctrl_wr),
        .i_limit (r_ctrl[CtrlPrescLsb +: PRESC_W]),
        .o_tick  (w_tick)
    );

    // Tick update first; a bus write then overrides only its enabled byte lanes.
    always_comb begin
        w_ctrl_d    = r_ctrl;
        w_compare_d = r_compare;
        w_match_clr = 1'b0;
        w_match_set = w_tick && (r_count == r_compare);

        w_cnt_ticked = r_count;
        if (w_tick) begin
            w_cnt_ticked = (w_match_set && r_ctrl[CtrlAutoBit]) ? 32'd0 : r_count + 32'd1;
        end
        w_count_d = w_cnt_ticked;

        if (w_wr) begin
            unique case (w_reg_sel)
                RegCtrl:    w_ctrl_d    = merge_bytes(r_ctrl, bus.data_i, bus.sel) & CtrlMask;
                RegCount:   w_count_d   = merge_bytes(w_cnt_ticked, bus.data_i, bus.sel);
                RegCompare: w_compare_d = merge_bytes(r_compare, bus.data_i, bus.sel);
                RegStatus:  w_match_clr = bus.sel[0] && bus.data_i[0];
            endcase
        end

        // A match in the same cycle as W1C keeps MATCH set.
        w_match_d = w_match_set || (r_match && !w_match_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_match   <= 1'b0;
        end else begin
            r_ctrl    <= w_ctrl_d;
            r_count   <= w_count_d;
            r_compare <= w_compare_d;
            r_match   <= w_match_d;
        end
    end

    always_comb begin
        bus.data_o = '0;
        if (w_hit && !bus.we) begin
            unique case (w_reg_sel)
                RegCtrl:    bus.data_o = r_ctrl;
                RegCount:   bus.data_o = r_count;
                RegCompare: bus.data_o = r_compare;
                RegStatus:  bus.data_o = {31'd0, r_match};
            endcase
        end
    end

    assign irq_o = r_match && r_ctrl[CtrlIrqEnBit];

endmodule
